// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and grant-select type for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 7;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_DBG   = 2;

    typedef enum logic [1:0] {
        SEL_FETCH = 2'(PORT_FETCH),
        SEL_DATA  = 2'(PORT_DATA),
        SEL_DBG   = 2'(PORT_DBG),
        SEL_NONE  = 2'd3
    } arb_sel_e;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of cycles a request has waited ungranted
module arb_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starved
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max  = (r_cnt == CNT_W'(MAX_WAIT));
    assign o_starved = w_at_max;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (!w_at_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch, data and debug requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_gnt,
    output logic [DATA_W-1:0] g_rdata,
    output logic              g_rvalid,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_in,
    input  logic [DATA_W-1:0] mem_d_out
);

    arb_sel_e          w_sel;
    logic              w_f_starved;
    logic              w_d_starved;
    logic              r_lock;
    logic              r_last_data;
    logic              r_f_rvalid;
    logic              r_d_rvalid;
    logic              r_g_rvalid;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_g_rdata;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_f_wait (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (f_req),
        .i_gnt     (f_gnt),
        .o_starved (w_f_starved)
    );

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_d_wait (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (d_req),
        .i_gnt     (d_gnt),
        .o_starved (w_d_starved)
    );

    // Grants are suppressed while rst is high so nothing reaches the memory during reset.
    always_comb begin
        w_sel = SEL_NONE;
        if (rst) begin
            w_sel = SEL_NONE;
        end else if (g_req) begin
            w_sel = SEL_DBG;
        end else if (w_f_starved && f_req) begin
            w_sel = SEL_FETCH;
        end else if (w_d_starved && d_req) begin
            w_sel = SEL_DATA;
        end else if (r_lock && d_req) begin
            w_sel = SEL_DATA;
        end else if (f_req && d_req) begin
            w_sel = r_last_data ? SEL_FETCH : SEL_DATA;
        end else if (f_req) begin
            w_sel = SEL_FETCH;
        end else if (d_req) begin
            w_sel = SEL_DATA;
        end
    end

    assign f_gnt = (w_sel == SEL_FETCH);
    assign d_gnt = (w_sel == SEL_DATA);
    assign g_gnt = (w_sel == SEL_DBG);

    always_comb begin
        mem_w_en = 1'b0;
        mem_addr = '0;
        mem_d_in = '0;
        case (w_sel)
            SEL_FETCH: begin
                mem_addr = f_addr;
            end
            SEL_DATA: begin
                mem_w_en = d_we;
                mem_addr = d_addr;
                mem_d_in = d_wdata;
            end
            SEL_DBG: begin
                mem_w_en = g_we;
                mem_addr = g_addr;
                mem_d_in = g_wdata;
            end
            default: begin
                mem_w_en = 1'b0;
            end
        endcase
    end

    // Response stage: the word on mem_d_out during the grant cycle is captured at its closing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_g_rvalid  <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_g_rdata   <= '0;
            r_lock      <= 1'b0;
            r_last_data <= 1'b1;
        end else begin
            r_f_rvalid <= f_gnt;
            r_d_rvalid <= d_gnt && !d_we;
            r_g_rvalid <= g_gnt && !g_we;
            if (f_gnt) begin
                r_f_rdata <= mem_d_out;
            end
            if (d_gnt && !d_we) begin
                r_d_rdata <= mem_d_out;
            end
            if (g_gnt && !g_we) begin
                r_g_rdata <= mem_d_out;
            end
            r_lock <= d_gnt && d_lock;
            if (f_gnt) begin
                r_last_data <= 1'b0;
            end else if (d_gnt) begin
                r_last_data <= 1'b1;
            end
        end
    end

    assign f_rvalid = r_f_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign g_rvalid = r_g_rvalid;
    assign f_rdata  = r_f_rdata;
    assign d_rdata  = r_d_rdata;
    assign g_rdata  = r_g_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req, f_gnt, f_rvalid;
    logic [9:0]  f_addr;
    logic [15:0] f_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [9:0]  d_addr;
    logic [15:0] d_wdata, d_rdata;
    logic        g_req, g_we, g_gnt, g_rvalid;
    logic [9:0]  g_addr;
    logic [15:0] g_wdata, g_rdata;
    logic        mem_w_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_d_in, mem_d_out;

    logic [15:0] tb_mem [0:1023];
    int          n_tests;
    int          n_fail;

    typedef struct {
        logic        f_req;
        logic [9:0]  f_addr;
        logic        d_req;
        logic        d_we;
        logic        d_lock;
        logic [9:0]  d_addr;
        logic [15:0] d_wdata;
        logic        g_req;
        logic        g_we;
        logic [9:0]  g_addr;
        logic [15:0] g_wdata;
        logic [2:0]  e_gnt;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [2:0]  e_rv;
        logic [15:0] e_rdata;
    } vec_t;

    localparam logic [2:0] GN = 3'b000;
    localparam logic [2:0] GF = 3'b001;
    localparam logic [2:0] GD = 3'b010;
    localparam logic [2:0] GG = 3'b100;

    vec_t tbl [16];

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rdata   (f_rdata),
        .f_rvalid  (f_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_lock    (d_lock),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .g_req     (g_req),
        .g_we      (g_we),
        .g_addr    (g_addr),
        .g_wdata   (g_wdata),
        .g_gnt     (g_gnt),
        .g_rdata   (g_rdata),
        .g_rvalid  (g_rvalid),
        .mem_w_en  (mem_w_en),
        .mem_addr  (mem_addr),
        .mem_d_in  (mem_d_in),
        .mem_d_out (mem_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_d_out = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_w_en) tb_mem[mem_addr] <= mem_d_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fr, input logic [9:0] fa,
                                input logic dr, input logic dw, input logic dl,
                                input logic [9:0] da, input logic [15:0] dd,
                                input logic gr, input logic gw,
                                input logic [9:0] ga, input logic [15:0] gd,
                                input logic [2:0] eg, input logic ew, input logic [9:0] ea,
                                input logic [2:0] erv, input logic [15:0] erd);
        vec_t v;
        v.f_req = fr; v.f_addr = fa;
        v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wdata = dd;
        v.g_req = gr; v.g_we = gw; v.g_addr = ga; v.g_wdata = gd;
        v.e_gnt = eg; v.e_we = ew; v.e_addr = ea; v.e_rv = erv; v.e_rdata = erd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] exp_din;
        f_req = v.f_req; f_addr = v.f_addr;
        d_req = v.d_req; d_we = v.d_we; d_lock = v.d_lock; d_addr = v.d_addr; d_wdata = v.d_wdata;
        g_req = v.g_req; g_we = v.g_we; g_addr = v.g_addr; g_wdata = v.g_wdata;
        exp_din = (v.e_gnt == GD) ? v.d_wdata : (v.e_gnt == GG) ? v.g_wdata : 16'h0;
        #1;
        chk({tag, " gnt"}, 32'({g_gnt, d_gnt, f_gnt}), 32'(v.e_gnt));
        chk({tag, " mem_w_en"}, 32'(mem_w_en), 32'(v.e_we));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({tag, " mem_d_in"}, 32'(mem_d_in), 32'(exp_din));
        chk({tag, " rvalid"}, 32'({g_rvalid, d_rvalid, f_rvalid}), 32'(v.e_rv));
        if (v.e_rv == GF) chk({tag, " f_rdata"}, 32'(f_rdata), 32'(v.e_rdata));
        if (v.e_rv == GD) chk({tag, " d_rdata"}, 32'(d_rdata), 32'(v.e_rdata));
        if (v.e_rv == GG) chk({tag, " g_rdata"}, 32'(g_rdata), 32'(v.e_rdata));
        @(negedge clk);
    endtask

    task automatic step(input logic fr, input logic dr, input logic dl, input logic gr,
                        input logic [2:0] eg, input string name);
        f_req = fr; f_addr = 10'h040;
        d_req = dr; d_we = 1'b0; d_lock = dl; d_addr = 10'h041; d_wdata = 16'h0;
        g_req = gr; g_we = 1'b0; g_addr = 10'h050; g_wdata = 16'h0;
        #1;
        chk(name, 32'({g_gnt, d_gnt, f_gnt}), 32'(eg));
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 16'hA000 | 16'(i);
        tb_mem[5] = 16'h1234;
        rst = 1'b1;
        f_req = 0; f_addr = 0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;
        g_req = 0; g_we = 0; g_addr = 0; g_wdata = 0;

        // cycle-by-cycle vectors: {inputs}, {gnt, we, addr, rvalid, rdata}
        tbl[0]  = mk(1, 10'h005, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GF, 0, 10'h005, GN, 16'h0000);
        tbl[1]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GN, 0, 10'h000, GF, 16'h1234);
        tbl[2]  = mk(1, 10'h020, 1, 0, 0, 10'h021, 16'h0000, 0, 0, 10'h000, 16'h0000, GD, 0, 10'h021, GN, 16'h0000);
        tbl[3]  = mk(1, 10'h020, 1, 0, 0, 10'h021, 16'h0000, 0, 0, 10'h000, 16'h0000, GF, 0, 10'h020, GD, 16'hA021);
        tbl[4]  = mk(1, 10'h020, 1, 0, 0, 10'h021, 16'h0000, 0, 0, 10'h000, 16'h0000, GD, 0, 10'h021, GF, 16'hA020);
        tbl[5]  = mk(1, 10'h020, 1, 0, 0, 10'h021, 16'h0000, 0, 0, 10'h000, 16'h0000, GF, 0, 10'h020, GD, 16'hA021);
        tbl[6]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GN, 0, 10'h000, GF, 16'hA020);
        tbl[7]  = mk(0, 10'h000, 1, 1, 0, 10'h010, 16'hCAFE, 0, 0, 10'h000, 16'h0000, GD, 1, 10'h010, GN, 16'h0000);
        tbl[8]  = mk(1, 10'h010, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GF, 0, 10'h010, GN, 16'h0000);
        tbl[9]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GN, 0, 10'h000, GF, 16'hCAFE);
        tbl[10] = mk(1, 10'h030, 1, 0, 0, 10'h031, 16'h0000, 1, 1, 10'h3FF, 16'hBEEF, GG, 1, 10'h3FF, GN, 16'h0000);
        tbl[11] = mk(1, 10'h030, 1, 0, 0, 10'h031, 16'h0000, 0, 0, 10'h000, 16'h0000, GD, 0, 10'h031, GN, 16'h0000);
        tbl[12] = mk(1, 10'h3FF, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GF, 0, 10'h3FF, GD, 16'hA031);
        tbl[13] = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GN, 0, 10'h000, GF, 16'hBEEF);
        tbl[14] = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h005, 16'h0000, GG, 0, 10'h005, GN, 16'h0000);
        tbl[15] = mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, GN, 0, 10'h000, GG, 16'h1234);

        #1;
        chk("reset gnt", 32'({g_gnt, d_gnt, f_gnt}), 32'(GN));
        chk("reset mem_w_en", 32'(mem_w_en), 32'd0);
        chk("reset rvalid", 32'({g_rvalid, d_rvalid, f_rvalid}), 32'd0);
        chk("reset rdata", 32'(f_rdata | d_rdata | g_rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

        chk("hold f_rdata", 32'(f_rdata), 32'h0000BEEF);
        chk("hold d_rdata", 32'(d_rdata), 32'h0000A031);
        chk("hold g_rdata", 32'(g_rdata), 32'h00001234);
        chk("hold rvalid", 32'({g_rvalid, d_rvalid, f_rvalid}), 32'd0);

        // lock burst: lock asserted on the first three data grants, released on the fourth
        step(1, 1, 1, 0, GD, "lock burst 1");
        step(1, 1, 1, 0, GD, "lock burst 2");
        step(1, 1, 1, 0, GD, "lock burst 3");
        step(1, 1, 0, 0, GD, "lock burst 4");
        step(1, 1, 0, 0, GF, "lock burst end fetch");

        // lock held indefinitely: fetch starves and wins on the 8th cycle of its wait
        for (int k = 0; k < 7; k++) step(1, 1, 1, 0, GD, $sformatf("starve data %0d", k));
        step(1, 1, 1, 0, GF, "starved fetch");
        step(1, 1, 1, 0, GD, "after starve data");
        step(1, 1, 1, 1, GG, "debug preempts lock");
        step(1, 1, 0, 0, GF, "lock cleared by debug");

        // reset asserted mid-cycle during a data read grant
        f_req = 0; g_req = 0; d_req = 1; d_we = 0; d_lock = 0; d_addr = 10'h041;
        #1;
        chk("pre-reset d_gnt", 32'(d_gnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("in-reset gnt", 32'({g_gnt, d_gnt, f_gnt}), 32'(GN));
        g_req = 1; g_we = 1; g_addr = 10'h060; g_wdata = 16'h5A5A;
        #0.5;
        chk("in-reset mem_w_en", 32'(mem_w_en), 32'd0);
        @(posedge clk);
        #1;
        chk("reset d_rvalid", 32'(d_rvalid), 32'd0);
        chk("reset d_rdata", 32'(d_rdata), 32'd0);
        @(negedge clk);
        g_req = 0; g_we = 0;
        f_req = 1; f_addr = 10'h040; d_req = 1; d_addr = 10'h041;
        rst = 1'b0;
        #1;
        chk("post-reset tie", 32'({g_gnt, d_gnt, f_gnt}), 32'(GF));
        @(posedge clk);
        #1;
        chk("post-reset f_rvalid", 32'(f_rvalid), 32'd1);
        chk("post-reset f_rdata", 32'(f_rdata), 32'h0000A040);
        chk("no write in reset", 32'(tb_mem[10'h060]), 32'h0000A060);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
